gptp_rx_parser: RTL and testbench

Receive-side counterpart of the gPTP transmit template: reassembles an incoming 352-bit gPTP frame from a byte stream, decodes the 4-bit messageType into the one-hot message selector used on the transmit side, and extracts the 80-bit timestamp/data field. It sits between the MAC receive byte interface and the gPTP timestamp/servo logic. Malformed frames are discarded.

---
 rtl/gptp_pkg.sv | 41 ++++
 rtl/gptp_mt_decode.sv | 25 ++
 rtl/gptp_rx_parser.sv | 162 ++++++++++++++++
 tb/tb_gptp_rx_parser.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gptp_pkg.sv
// gPTP shared definitions: messageType codes, one-hot selector bit positions,
// frame geometry, receive FSM state encoding and a saturating counter helper.
// Also consumed by the transmit template.
package gptp_pkg;

  // messageType codes carried in byte 0 bits [3:0]
  localparam logic [3:0] MT_SYNC           = 4'h0;
  localparam logic [3:0] MT_FOLLOW_UP      = 4'h8;
  localparam logic [3:0] MT_PDELAY_REQ     = 4'h2;
  localparam logic [3:0] MT_PDELAY_RESP    = 4'h3;
  localparam logic [3:0] MT_PDELAY_RESP_FU = 4'hA;

  // Bit positions inside the 8-bit one-hot message selector
  localparam int SEL_SYNC           = 0;
  localparam int SEL_FOLLOW_UP      = 1;
  localparam int SEL_PDELAY_REQ     = 2;
  localparam int SEL_PDELAY_RESP    = 3;
  localparam int SEL_PDELAY_RESP_FU = 4;

  // Frame geometry: 44 bytes, data field starts at byte 34
  localparam int FRAME_BYTES = 44;
  localparam int DATA_OFS    = 34;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } rx_state_e;

  // 16-bit add of a small increment, clamping at all-ones
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    if (sum[16]) begin
      return 16'hFFFF;
    end else begin
      return sum[15:0];
    end
  endfunction

endpackage

// File: rtl/gptp_mt_decode.sv
// Combinational messageType -> one-hot selector decode with a known-type flag.
// Inverse of the transmit-side selector encoding; bits 7:5 are never set.
module gptp_mt_decode
  import gptp_pkg::*;
(
  input  logic [3:0] i_type,
  output logic [7:0] o_sel,
  output logic       o_known
);

  // Map each supported messageType onto its selector bit
  always_comb begin
    o_sel   = 8'h00;
    o_known = 1'b0;
    case (i_type)
      MT_SYNC:           begin o_sel[SEL_SYNC]           = 1'b1; o_known = 1'b1; end
      MT_FOLLOW_UP:      begin o_sel[SEL_FOLLOW_UP]      = 1'b1; o_known = 1'b1; end
      MT_PDELAY_REQ:     begin o_sel[SEL_PDELAY_REQ]     = 1'b1; o_known = 1'b1; end
      MT_PDELAY_RESP:    begin o_sel[SEL_PDELAY_RESP]    = 1'b1; o_known = 1'b1; end
      MT_PDELAY_RESP_FU: begin o_sel[SEL_PDELAY_RESP_FU] = 1'b1; o_known = 1'b1; end
      default:           begin o_sel = 8'h00;                    o_known = 1'b0; end
    endcase
  end

endmodule

// File: rtl/gptp_rx_parser.sv
// gPTP receive parser: reassembles a 44-byte frame from the MAC byte stream,
// decodes messageType into the one-hot selector and extracts the 80-bit data
// field (bytes 34..43). Malformed frames are discarded without touching the
// held outputs. Optional feature macro GPTP_RX_ERRCNT_EN adds the drop_cnt
// port and its saturating counter.
module gptp_rx_parser #(
  parameter int FRAME_BYTES = gptp_pkg::FRAME_BYTES,
  parameter int DATA_OFS    = gptp_pkg::DATA_OFS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_sof,
  input  logic        rx_eof,
  output logic        recv_valid,
  output logic [7:0]  recv_addr,
  output logic [79:0] recv_data
`ifdef GPTP_RX_ERRCNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  localparam logic [5:0] LP_FRAME = 6'(FRAME_BYTES);
  localparam logic [5:0] LP_LAST  = 6'(FRAME_BYTES - 1);
  localparam logic [5:0] LP_DOFS  = 6'(DATA_OFS);

  gptp_pkg::rx_state_e r_state, w_state_nxt;
  logic [5:0]  r_byte_cnt, w_cnt_nxt, w_cnt_inc;
  logic [3:0]  r_type, w_type_nxt;
  logic [79:0] r_shadow;
  logic        r_recv_valid;
  logic [7:0]  r_recv_addr;
  logic [79:0] r_recv_data;
  logic        w_shadow_we, w_load, w_known;
  logic [1:0]  w_drop_inc;
  logic [7:0]  w_sel;
  logic [6:0]  w_bit_ofs;

  gptp_mt_decode u_mt_decode (
    .i_type  (r_type),
    .o_sel   (w_sel),
    .o_known (w_known)
  );

  assign w_cnt_inc = (r_byte_cnt == 6'd63) ? 6'd63 : (r_byte_cnt + 6'd1);
  assign w_bit_ofs = 7'({1'b0, 6'(r_byte_cnt - LP_DOFS)} << 3);

  // Next-state, byte accounting and frame verdict for the current input byte
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_byte_cnt;
    w_type_nxt  = r_type;
    w_shadow_we = 1'b0;
    w_load      = 1'b0;
    w_drop_inc  = 2'd0;
    if (rx_valid && rx_sof) begin
      // A new frame always starts here; anything in flight is aborted
      w_type_nxt = rx_data[3:0];
      if (rx_eof) begin
        w_state_nxt = gptp_pkg::ST_IDLE;
        w_cnt_nxt   = 6'd0;
        w_drop_inc  = (r_state == gptp_pkg::ST_IDLE) ? 2'd1 : 2'd2;
      end else begin
        w_state_nxt = gptp_pkg::ST_RECV;
        w_cnt_nxt   = 6'd1;
        w_drop_inc  = (r_state == gptp_pkg::ST_IDLE) ? 2'd0 : 2'd1;
      end
    end else if (rx_valid) begin
      case (r_state)
        gptp_pkg::ST_RECV: begin
          w_shadow_we = (r_byte_cnt >= LP_DOFS) && (r_byte_cnt < LP_FRAME);
          if (rx_eof) begin
            w_state_nxt = gptp_pkg::ST_IDLE;
            w_cnt_nxt   = 6'd0;
            if ((r_byte_cnt == LP_LAST) && w_known) begin
              w_load = 1'b1;
            end else begin
              w_drop_inc = 2'd1;
            end
          end else begin
            w_cnt_nxt   = w_cnt_inc;
            w_state_nxt = (w_cnt_inc >= LP_FRAME) ? gptp_pkg::ST_DROP : gptp_pkg::ST_RECV;
          end
        end
        gptp_pkg::ST_DROP: begin
          if (rx_eof) begin
            w_state_nxt = gptp_pkg::ST_IDLE;
            w_cnt_nxt   = 6'd0;
            w_drop_inc  = 2'd1;
          end else begin
            w_state_nxt = gptp_pkg::ST_DROP;
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        default: begin
          // IDLE ignores bytes that do not open a frame
          w_state_nxt = gptp_pkg::ST_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM state and byte counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= gptp_pkg::ST_IDLE;
      r_byte_cnt <= 6'd0;
      r_type     <= 4'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_cnt_nxt;
      r_type     <= w_type_nxt;
    end
  end

  // Data shadow capture and registered outputs, loaded only on a good frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow     <= 80'd0;
      r_recv_valid <= 1'b0;
      r_recv_addr  <= 8'h00;
      r_recv_data  <= 80'd0;
    end else begin
      if (w_shadow_we) begin
        r_shadow[w_bit_ofs +: 8] <= rx_data;
      end
      r_recv_valid <= w_load;
      if (w_load) begin
        // The eof byte is the last data byte, so merge it in directly
        r_recv_addr <= w_sel;
        r_recv_data <= {rx_data, r_shadow[71:0]};
      end
    end
  end

  assign recv_valid = r_recv_valid;
  assign recv_addr  = r_recv_addr;
  assign recv_data  = r_recv_data;

`ifdef GPTP_RX_ERRCNT_EN
  logic [15:0] r_drop_cnt;

  // Saturating count of discarded frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= 16'h0000;
    end else begin
      r_drop_cnt <= gptp_pkg::sat_add16(r_drop_cnt, w_drop_inc);
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  logic w_unused_drop;
  assign w_unused_drop = ^w_drop_inc;
`endif

endmodule

// File: tb/tb_gptp_rx_parser.sv
// Self-checking bench for gptp_rx_parser: table of directed frames, hand
// sequences for abort / back-to-back / mid-frame reset, then random frames
// checked against a frame-level reference model.
module tb_gptp_rx_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_sof;
  logic        rx_eof;
  logic        recv_valid;
  logic [7:0]  recv_addr;
  logic [79:0] recv_data;
`ifdef GPTP_RX_ERRCNT_EN
  logic [15:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]  m_addr;
  logic [79:0] m_data;
  int          m_drop;
  bit          m_pending;
  bit          exp_pulse;
  bit          seen_pulse;
  int          pulse_cnt;
  logic [7:0]  fb [64];

  gptp_rx_parser dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_sof     (rx_sof),
    .rx_eof     (rx_eof),
    .recv_valid (recv_valid),
    .recv_addr  (recv_addr),
    .recv_data  (recv_data)
`ifdef GPTP_RX_ERRCNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {known, one-hot} from the messageType table
  function automatic logic [8:0] ref_type(input logic [3:0] t);
    case (t)
      4'h0:    return {1'b1, 8'h01};
      4'h8:    return {1'b1, 8'h02};
      4'h2:    return {1'b1, 8'h04};
      4'h3:    return {1'b1, 8'h08};
      4'hA:    return {1'b1, 8'h10};
      default: return 9'h000;
    endcase
  endfunction

  // One clock: check what the previous edge produced, then drive the next inputs
  task automatic tick(input logic v, input logic [7:0] d, input logic s, input logic e);
    @(negedge clk);
    chk("recv_valid", recv_valid, exp_pulse);
    if (exp_pulse) begin
      chk("recv_addr", recv_addr, m_addr);
      chk("recv_data", recv_data, m_data);
    end
    if (recv_valid) begin
      seen_pulse = 1'b1;
      pulse_cnt++;
    end
    exp_pulse = 1'b0;
    rx_valid = v;
    rx_data  = d;
    rx_sof   = s;
    rx_eof   = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic check_held();
    chk("held_addr", recv_addr, m_addr);
    chk("held_data", recv_data, m_data);
`ifdef GPTP_RX_ERRCNT_EN
    chk("drop_cnt", drop_cnt, 80'(m_drop));
`endif
  endtask

  task automatic fill_frame(input logic [7:0] b0);
    for (int k = 0; k < 64; k++) fb[k] = 8'($urandom);
    fb[0] = b0;
  endtask

  // Send fb[0..len-1]; random invalid gap cycles of 1..gapmax; update the model
  task automatic send(input int len, input int gapmax, input bit do_eof);
    logic [8:0]  ti;
    logic [79:0] d;
    seen_pulse = 1'b0;
    if (m_pending) begin
      m_drop++;
      m_pending = 1'b0;
    end
    for (int i = 0; i < len; i++) begin
      if (i > 0 && gapmax > 0 && $urandom_range(0, 1) == 1) begin
        idle($urandom_range(1, gapmax));
      end
      tick(1'b1, fb[i], 1'(i == 0), 1'(do_eof && i == len - 1));
    end
    ti = ref_type(fb[0][3:0]);
    if (do_eof) begin
      if (len == 44 && ti[8]) begin
        for (int k = 0; k < 10; k++) d[8*k +: 8] = fb[34 + k];
        m_addr    = ti[7:0];
        m_data    = d;
        exp_pulse = 1'b1;
      end else begin
        m_drop++;
      end
    end else begin
      m_pending = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0] b0;
    int         len;
    int         gapmax;
    bit         exp_good;
    logic [7:0] exp_addr;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int p0;
    tbl[0] = '{8'h00, 44, 0, 1'b1, 8'h01};
    tbl[1] = '{8'h1A, 44, 0, 1'b1, 8'h10};
    tbl[2] = '{8'h05, 44, 0, 1'b0, 8'h00};
    tbl[3] = '{8'h08, 43, 0, 1'b0, 8'h00};
    tbl[4] = '{8'h08, 46, 0, 1'b0, 8'h00};
    tbl[5] = '{8'h03, 44, 0, 1'b1, 8'h08};
    tbl[6] = '{8'h08, 44, 3, 1'b1, 8'h02};
    tbl[7] = '{8'h0F, 44, 1, 1'b0, 8'h00};
    tbl[8] = '{8'h00,  1, 0, 1'b0, 8'h00};
    tbl[9] = '{8'h2A, 44, 2, 1'b1, 8'h10};

    m_addr = 8'h00; m_data = 80'd0; m_drop = 0; m_pending = 1'b0;
    exp_pulse = 1'b0; seen_pulse = 1'b0; pulse_cnt = 0;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_sof = 1'b0; rx_eof = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", recv_valid, 1'b0);
    check_held();
    rst = 1'b0;
    idle(2);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      fill_frame(tbl[i].b0);
      if (i == 0) begin
        for (int k = 34; k < 44; k++) fb[k] = 8'(k - 33);
      end
      send(tbl[i].len, tbl[i].gapmax, 1'b1);
      idle(2);
      chk("tbl_pulse", seen_pulse, tbl[i].exp_good);
      if (tbl[i].exp_good) chk("tbl_addr", recv_addr, tbl[i].exp_addr);
      if (i == 0) chk("tbl_data", recv_data, 80'h0A090807060504030201);
      check_held();
    end

    // sof at byte 20 aborts a frame, next frame type 0x2 is good
    fill_frame(8'h08);
    send(20, 0, 1'b0);
    fill_frame(8'h02);
    send(44, 0, 1'b1);
    idle(2);
    chk("abort_addr", recv_addr, 8'h04);
    check_held();

    // Back-to-back good frames
    p0 = pulse_cnt;
    fill_frame(8'h00);
    send(44, 0, 1'b1);
    fill_frame(8'h0A);
    send(44, 0, 1'b1);
    idle(2);
    chk("b2b_pulses", 80'(pulse_cnt - p0), 80'd2);
    check_held();

    // Reset at byte 30
    fill_frame(8'h03);
    send(30, 0, 1'b0);
    #2;
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    m_addr = 8'h00; m_data = 80'd0; m_drop = 0; m_pending = 1'b0; exp_pulse = 1'b0;
    chk("rst_mid_valid", recv_valid, 1'b0);
    check_held();
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    fill_frame(8'h03);
    send(44, 0, 1'b1);
    idle(2);
    chk("post_rst_addr", recv_addr, 8'h08);
    check_held();

    // Random frames against the reference model
    for (int n = 0; n < 50; n++) begin
      int r;
      int len;
      bit eof;
      fill_frame(8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 4))
          0:       fb[0][3:0] = 4'h0;
          1:       fb[0][3:0] = 4'h8;
          2:       fb[0][3:0] = 4'h2;
          3:       fb[0][3:0] = 4'h3;
          default: fb[0][3:0] = 4'hA;
        endcase
      end
      r   = $urandom_range(0, 9);
      eof = 1'b1;
      if (r <= 5)      len = 44;
      else if (r == 6) len = 43;
      else if (r == 7) len = 45;
      else if (r == 8) len = $urandom_range(1, 60);
      else begin
        len = $urandom_range(2, 50);
        eof = 1'b0;
      end
      send(len, $urandom_range(0, 3), eof);
      if ($urandom_range(0, 1) == 1) begin
        idle($urandom_range(1, 3));
        check_held();
      end
    end
    idle(3);
    check_held();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always terminates
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
